edge_scanner: RTL and testbench

Raster scan controller that drives the pixel coordinate bus into the array of edge-function units and collects their per-edge hit flags into one video pixel. It generates VGA-style horizontal/vertical timing. It delays sync and data-enable by the edge units' fixed pipeline latency so that sync, enable and pixel leave the block aligned. It also provides a frame counter and a once-per-frame vertical-blank strobe, so upstream logic can update line endpoints and thresholds while nothing is being drawn.

---
 rtl/edge_scanner.sv | 137 +++++++++++++
 tb/tb_edge_scanner.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_scanner.sv
// edge_scanner: raster scan controller for the edge-function array.
// It generates VGA-style timing, broadcasts the pixel coordinate to the edge units and merges
// their hit flags into one video pixel. Sync and enable are delayed to line up with that pixel.

module edge_scanner #(
    parameter int unsigned LINE_BITS    = 10,
    parameter int unsigned NUM_EDGES    = 12,
    parameter int unsigned PIPE_LATENCY = 2,
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_FRONT      = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BACK       = 48,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_FRONT      = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BACK       = 33,
    parameter int unsigned FRAME_BITS   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic [LINE_BITS-1:0]  pixel_x_o,
    output logic [LINE_BITS-1:0]  pixel_y_o,
    input  logic [NUM_EDGES-1:0]  pixel_set_i,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic                  de_o,
    output logic                  pixel_o,
    output logic                  vblank_start_o,
    output logic [FRAME_BITS-1:0] frame_cnt_o
);

    localparam int unsigned H_TOTAL    = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL    = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FRONT;
    localparam int unsigned H_SYNC_END = H_ACTIVE + H_FRONT + H_SYNC;
    localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FRONT;
    localparam int unsigned V_SYNC_END = V_ACTIVE + V_FRONT + V_SYNC;

    // Pipeline entry layout {de, hs, vs}; idle means no enable and both syncs released (high).
    localparam logic [2:0] PIPE_IDLE = 3'b011;

    logic [LINE_BITS-1:0]  r_h_cnt;
    logic [LINE_BITS-1:0]  r_v_cnt;
    logic [FRAME_BITS-1:0] r_frame_cnt;
    logic [2:0]            r_pipe [PIPE_LATENCY];
    logic                  r_de;
    logic                  r_hs;
    logic                  r_vs;
    logic                  r_pix;

    logic [31:0] w_h_cnt;
    logic [31:0] w_v_cnt;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_de_raw;
    logic        w_hs_raw;
    logic        w_vs_raw;
    logic [2:0]  w_tail;
    logic        w_hit;

    // Counters widened to 32 bits so comparisons against the timing constants never truncate.
    assign w_h_cnt  = 32'(r_h_cnt);
    assign w_v_cnt  = 32'(r_v_cnt);
    assign w_h_last = (w_h_cnt == H_TOTAL - 1);
    assign w_v_last = (w_v_cnt == V_TOTAL - 1);

    // Raw (undelayed) timing decode from the counter registers.
    always_comb begin
        w_de_raw = (w_h_cnt < H_ACTIVE) && (w_v_cnt < V_ACTIVE);
        w_hs_raw = !((w_h_cnt >= H_SYNC_BEG) && (w_h_cnt < H_SYNC_END));
        w_vs_raw = !((w_v_cnt >= V_SYNC_BEG) && (w_v_cnt < V_SYNC_END));
    end

    // Horizontal/vertical raster counters and completed-frame counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_frame_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            if (w_v_last) begin
                r_v_cnt     <= '0;
                r_frame_cnt <= r_frame_cnt + FRAME_BITS'(1);
            end else begin
                r_v_cnt <= r_v_cnt + LINE_BITS'(1);
            end
        end else begin
            r_h_cnt <= r_h_cnt + LINE_BITS'(1);
        end
    end

    // Delay line matching the edge units' latency; reset flushes it to idle so no stale sync
    // pulse can leave the block after a mid-frame reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                r_pipe[i] <= PIPE_IDLE;
            end
        end else begin
            r_pipe[0] <= {w_de_raw, w_hs_raw, w_vs_raw};
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_tail = r_pipe[PIPE_LATENCY-1];
    assign w_hit  = |pixel_set_i;

    // Output register: hits are masked by the delayed enable so blanking never draws.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_de  <= 1'b0;
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
            r_pix <= 1'b0;
        end else begin
            r_de  <= w_tail[2];
            r_hs  <= w_tail[1];
            r_vs  <= w_tail[0];
            r_pix <= w_tail[2] & w_hit;
        end
    end

    assign pixel_x_o   = r_h_cnt;
    assign pixel_y_o   = r_v_cnt;
    assign hsync_o     = r_hs;
    assign vsync_o     = r_vs;
    assign de_o        = r_de;
    assign pixel_o     = r_pix;
    assign frame_cnt_o = r_frame_cnt;

    // Undelayed strobe: upstream updates its registers while nothing is on screen.
    assign vblank_start_o = !rst_i && (r_h_cnt == '0) && (w_v_cnt == V_ACTIVE);

endmodule

// File: tb/tb_edge_scanner.sv
// Bench for edge_scanner: a default-timing instance and a tiny-timing instance (FRAME_BITS=2)
// checked every cycle against a model computed from the elapsed cycle count.

module tb_edge_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        d_rst = 1'b1;
    logic        s_rst = 1'b1;
    logic [11:0] pset  = '0;

    logic [9:0] d_x, d_y;
    logic       d_hs, d_vs, d_de, d_pix, d_vb;
    logic [7:0] d_frame;

    logic [3:0] s_x, s_y;
    logic       s_hs, s_vs, s_de, s_pix, s_vb;
    logic [1:0] s_frame;

    edge_scanner u_dut_dflt (
        .clk_i          (clk),
        .rst_i          (d_rst),
        .pixel_x_o      (d_x),
        .pixel_y_o      (d_y),
        .pixel_set_i    (pset),
        .hsync_o        (d_hs),
        .vsync_o        (d_vs),
        .de_o           (d_de),
        .pixel_o        (d_pix),
        .vblank_start_o (d_vb),
        .frame_cnt_o    (d_frame)
    );

    edge_scanner #(
        .LINE_BITS  (4),
        .H_ACTIVE   (4),
        .H_FRONT    (1),
        .H_SYNC     (1),
        .H_BACK     (1),
        .V_ACTIVE   (3),
        .V_FRONT    (1),
        .V_SYNC     (1),
        .V_BACK     (1),
        .FRAME_BITS (2)
    ) u_dut_small (
        .clk_i          (clk),
        .rst_i          (s_rst),
        .pixel_x_o      (s_x),
        .pixel_y_o      (s_y),
        .pixel_set_i    (pset),
        .hsync_o        (s_hs),
        .vsync_o        (s_vs),
        .de_o           (s_de),
        .pixel_o        (s_pix),
        .vblank_start_o (s_vb),
        .frame_cnt_o    (s_frame)
    );

    typedef struct {
        int x;
        int y;
        int frame;
        bit de;
        bit hs;
        bit vs;
        bit vb;
    } exp_t;

    int errors = 0;
    int checks = 0;
    int n = 0;
    bit sel = 1'b0;
    bit rst_now = 1'b1;
    bit rst_pending = 1'b0;
    bit prev_any = 1'b0;
    bit track = 1'b0;
    int ha, hf, hsw, hb, va, vf, vsw, vbk, lat, fb;
    int qx[$];
    int qy[$];
    int pix_hi_cnt, pix_hi_at, hs_low_cnt, de_cnt, first_hs_low, vb_cnt;
    int fr_seq[$];

    logic [31:0] ox, oy, ofr;
    logic        ohs, ovs, ode, opix, ovb;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s (inst=%0d n=%0d): got %0d, expected %0d", tag, sel, n, obs, exp);
        end
    endtask

    // Expected state after t cycles since reset release, straight from the timing rules.
    function automatic exp_t ref_at(input int t);
        exp_t e;
        int ht, vt, m, xm, ym;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vbk;
        e.x     = t % ht;
        e.y     = (t / ht) % vt;
        e.frame = (t / (ht * vt)) % (1 << fb);
        e.vb    = (e.x == 0) && (e.y == va);
        m = t - (lat + 1);
        if (m < 0) begin
            e.de = 1'b0;
            e.hs = 1'b1;
            e.vs = 1'b1;
        end else begin
            xm = m % ht;
            ym = (m / ht) % vt;
            e.de = (xm < ha) && (ym < va);
            e.hs = !((xm >= ha + hf) && (xm < ha + hf + hsw));
            e.vs = !((ym >= va + vf) && (ym < va + vf + vsw));
        end
        return e;
    endfunction

    task automatic set_rst(input bit v);
        rst_now = v;
        if (sel) s_rst = v;
        else d_rst = v;
    endtask

    task automatic sample();
        if (sel) begin
            ox = 32'(s_x); oy = 32'(s_y); ofr = 32'(s_frame);
            ohs = s_hs; ovs = s_vs; ode = s_de; opix = s_pix; ovb = s_vb;
        end else begin
            ox = 32'(d_x); oy = 32'(d_y); ofr = 32'(d_frame);
            ohs = d_hs; ovs = d_vs; ode = d_de; opix = d_pix; ovb = d_vb;
        end
    endtask

    // mode 0: edge model hits bit 5 for (100,50); mode 1: all ones; otherwise sparse random.
    task automatic do_cycle(input int mode);
        exp_t        e;
        logic [11:0] v;
        int          cx, cy;
        sample();
        e = ref_at(n);
        check_eq("pixel_x", ox, e.x);
        check_eq("pixel_y", oy, e.y);
        check_eq("hsync", ohs, e.hs);
        check_eq("vsync", ovs, e.vs);
        check_eq("de", ode, e.de);
        check_eq("pixel", opix, e.de && prev_any);
        check_eq("vblank_start", ovb, e.vb && !rst_now);
        check_eq("frame_cnt", ofr, e.frame);
        if (track) begin
            if (!sel) begin
                if (opix === 1'b1) begin
                    pix_hi_cnt++;
                    pix_hi_at = n;
                    check_eq("pixel_with_de", ode, 1);
                end
                if (n < 1600) begin
                    if (ohs === 1'b0) begin
                        hs_low_cnt++;
                        if (first_hs_low < 0) first_hs_low = n;
                    end
                    if (ode === 1'b1) de_cnt++;
                end
            end else begin
                if (ovb === 1'b1) vb_cnt++;
                if (fr_seq.size() == 0 || fr_seq[fr_seq.size()-1] != int'(ofr))
                    fr_seq.push_back(int'(ofr));
            end
        end
        qx.push_back(int'(ox));
        qy.push_back(int'(oy));
        if (qx.size() > 8) begin
            void'(qx.pop_front());
            void'(qy.pop_front());
        end
        v = '0;
        case (mode)
            0: begin
                if (qx.size() > lat) begin
                    cx = qx[qx.size()-1-lat];
                    cy = qy[qy.size()-1-lat];
                    if (cx == 100 && cy == 50) v[5] = 1'b1;
                end
            end
            1: v = '1;
            default: if ($urandom_range(0, 3) == 0) v = 12'($urandom);
        endcase
        pset = v;
        prev_any = |v;
    endtask

    task automatic restart();
        n = 0;
        prev_any = 1'b0;
        rst_pending = 1'b0;
        qx.delete();
        qy.delete();
    endtask

    task automatic reset_seq(input int cycles, input int mode);
        set_rst(1'b1);
        for (int j = 0; j < cycles; j++) begin
            @(posedge clk);
            #2;
            sample();
            check_eq("rst_hsync", ohs, 1);
            check_eq("rst_vsync", ovs, 1);
            check_eq("rst_de", ode, 0);
            check_eq("rst_pixel", opix, 0);
            check_eq("rst_frame_cnt", ofr, 0);
            check_eq("rst_vblank", ovb, 0);
            check_eq("rst_pixel_x", ox, 0);
        end
        set_rst(1'b0);
        restart();
        do_cycle(mode);
    endtask

    // reset_at >= 0 raises rst_i for exactly one cycle at that iteration.
    task automatic run(input int cycles, input int mode, input int reset_at);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (rst_pending) begin
                set_rst(1'b0);
                restart();
            end else begin
                n++;
            end
            if (i == reset_at) begin
                set_rst(1'b1);
                rst_pending = 1'b1;
            end
            #1;
            do_cycle(mode);
        end
    endtask

    int r;
    int exp_fr[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        // Default timing instance.
        sel = 1'b0;
        ha = 640; hf = 16; hsw = 96; hb = 48;
        va = 480; vf = 10; vsw = 2; vbk = 33;
        lat = 2; fb = 8;
        pix_hi_cnt = 0; pix_hi_at = -1; hs_low_cnt = 0; de_cnt = 0; first_hs_low = -1;
        track = 1'b1;
        reset_seq(5, 0);
        run(40299, 0, -1);
        track = 1'b0;
        check_eq("pixel_hits", pix_hi_cnt, 1);
        check_eq("pixel_hit_cycle", pix_hi_at, 40103);
        check_eq("hsync_low_2lines", hs_low_cnt, 192);
        check_eq("hsync_first_low", first_hs_low, 659);
        check_eq("de_high_2lines", de_cnt, 1280);
        r = int'($urandom_range(50, 400));
        run(r + 1, 2, r);
        run(1700, 2, -1);

        // Tiny timing instance: frame strobe, wrap and blanking mask.
        sel = 1'b1;
        ha = 4; hf = 1; hsw = 1; hb = 1;
        va = 3; vf = 1; vsw = 1; vbk = 1;
        lat = 2; fb = 2;
        vb_cnt = 0;
        fr_seq.delete();
        track = 1'b1;
        reset_seq(5, 2);
        run(41, 2, -1);
        run(42, 1, -1);
        run(147, 2, -1);
        track = 1'b0;
        check_eq("vblank_pulses", vb_cnt, 5);
        check_eq("frame_steps", fr_seq.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < fr_seq.size()) check_eq("frame_seq", fr_seq[k], exp_fr[k]);
        end
        // Reset lands on the cycle the strobe would fire; it must stay low.
        run(1, 2, 0);
        run(120, 2, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
